dro_pulse_sequencer: RTL and testbench

- Clocked upstream driver for a basic_dro cell.
- Accepts queued write/read commands and converts them into toggle-coded edges on the cell's set and reset inputs. The cell reacts to both posedge and negedge.
- Enforces a minimum clock-cycle separation between opposite-line edges so the cell's set/reset hold windows are never violated.
- Sits between test/control logic and the DRO cell.

---
 rtl/dro_pulse_sequencer_if.sv | 12 +
 rtl/dro_pulse_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dro_pulse_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dro_pulse_sequencer_if.sv
// Command handshake between control logic and dro_pulse_sequencer.
//   cmd_valid : command offered by the master
//   cmd_ready : sequencer FIFO not full (registered occupancy only)
//   cmd_op    : 00 NOP, 01 WRITE1, 10 READ, 11 WRITE1_READ
interface dro_pulse_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/dro_pulse_sequencer.sv
// Clocked driver for a basic_dro cell. Queued WRITE1/READ commands become
// toggle-coded edges on set/reset, with a minimum gap between edges on
// opposite lines so the cell's hold windows are respected.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cmd         : command handshake (slave side of dro_pulse_sequencer_if)
//   set, reset  : toggle-coded lines to the DRO
//   busy        : FIFO non-empty or FSM not idle
//   issued_cnt  : wrapping count of all edges issued
//   dro_out     : DRO output, used only by the shadow checker
//   mismatch    : sticky shadow-check error
// Optional: define DRO_SHADOW_CHECK_EN to build the shadow DRO checker;
// otherwise dro_out is ignored and mismatch is tied low.
module dro_pulse_sequencer #(
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned QDEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  dro_pulse_sequencer_if.slave        cmd,
  output logic                        set,
  output logic                        reset,
  output logic                        busy,
  output logic [15:0]                 issued_cnt,
  input  logic                        dro_out,
  output logic                        mismatch
);

  typedef enum logic [1:0] {StIdle, StExecSet, StExecRd} state_e;

  localparam int unsigned PtrW   = $clog2(QDEPTH);
  localparam logic [PtrW:0] Depth = (PtrW+1)'(QDEPTH);
  localparam logic [3:0] GapMax  = 4'(GAP_CYCLES);
  // Gap counter is compared before it increments on this edge.
  localparam logic [3:0] GapOk   = 4'(GAP_CYCLES - 1);

  // Command FIFO
  logic [1:0]    mem_q [QDEPTH];
  logic [PtrW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full, empty, push, pop;
  logic [1:0]    head;

  assign full          = (wr_ptr_q - rd_ptr_q) == Depth;
  assign empty         = wr_ptr_q == rd_ptr_q;
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign head          = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= cmd.cmd_op;
  end

  // Sequencer state
  state_e      state_q, state_d;
  logic [1:0]  cur_op_q, cur_op_d;
  logic        set_q, set_d, reset_q, reset_d;
  logic        has_last_q, has_last_d;  // cleared means no edge since reset
  logic        last_rd_q, last_rd_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] cnt_q, cnt_d;
  logic        set_ok, rd_ok, set_edge, rd_edge;

  assign set_ok = !has_last_q || !last_rd_q || (gap_q >= GapOk);
  assign rd_ok  = !has_last_q ||  last_rd_q || (gap_q >= GapOk);

  always_comb begin
    state_d    = state_q;
    cur_op_d   = cur_op_q;
    set_d      = set_q;
    reset_d    = reset_q;
    has_last_d = has_last_q;
    last_rd_d  = last_rd_q;
    gap_d      = (gap_q == GapMax) ? gap_q : gap_q + 4'd1;
    set_edge   = 1'b0;
    rd_edge    = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          cur_op_d = head;
          if (head[0])      state_d = StExecSet;
          else if (head[1]) state_d = StExecRd;
        end
      end
      StExecSet: begin
        if (set_ok) begin
          set_edge   = 1'b1;
          set_d      = !set_q;
          has_last_d = 1'b1;
          last_rd_d  = 1'b0;
          gap_d      = 4'd0;
          state_d    = cur_op_q[1] ? StExecRd : StIdle;
        end
      end
      StExecRd: begin
        if (rd_ok) begin
          rd_edge    = 1'b1;
          reset_d    = !reset_q;
          has_last_d = 1'b1;
          last_rd_d  = 1'b1;
          gap_d      = 4'd0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = (set_edge || rd_edge) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_op_q   <= 2'b00;
      set_q      <= 1'b0;
      reset_q    <= 1'b0;
      has_last_q <= 1'b0;
      last_rd_q  <= 1'b0;
      gap_q      <= 4'd0;
      cnt_q      <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_op_q   <= cur_op_d;
      set_q      <= set_d;
      reset_q    <= reset_d;
      has_last_q <= has_last_d;
      last_rd_q  <= last_rd_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign set        = set_q;
  assign reset      = reset_q;
  assign issued_cnt = cnt_q;
  assign busy       = !empty || (state_q != StIdle);

`ifdef DRO_SHADOW_CHECK_EN
  // Shadow DRO: once written it stays set, and every read flips its output.
  logic       shadow_q, shadow_d, exp_out_q, exp_out_d;
  logic       sync1_q, sync2_q, mismatch_q, mismatch_d;
  logic [2:0] quiet_q, quiet_d;  // cycles since last reset edge, saturating at 4

  always_comb begin
    shadow_d   = shadow_q | set_edge;
    exp_out_d  = exp_out_q ^ (rd_edge & shadow_q);
    quiet_d    = rd_edge ? 3'd0 : ((quiet_q == 3'd4) ? quiet_q : quiet_q + 3'd1);
    mismatch_d = mismatch_q | ((quiet_q == 3'd4) && (sync2_q != exp_out_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= 1'b0;
      exp_out_q  <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      quiet_q    <= 3'd4;
      mismatch_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      exp_out_q  <= exp_out_d;
      sync1_q    <= dro_out;
      sync2_q    <= sync1_q;
      quiet_q    <= quiet_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_dro_out;
  assign unused_dro_out = dro_out;
  assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_dro_pulse_sequencer.sv
`timescale 1ns/1ps
module tb_dro_pulse_sequencer;
  localparam int unsigned GAP = 3;
  localparam int unsigned QD  = 4;
  localparam logic [1:0] OP_NOP = 2'b00, OP_W1 = 2'b01, OP_RD = 2'b10, OP_W1R = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        set, reset, busy, dro_out, mismatch;
  logic [15:0] issued_cnt;

  dro_pulse_sequencer_if cmd_if ();

  dro_pulse_sequencer #(.GAP_CYCLES(GAP), .QDEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if.slave),
    .set        (set),
    .reset      (reset),
    .busy       (busy),
    .issued_cnt (issued_cnt),
    .dro_out    (dro_out),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected edges: line 0 = set, 1 = reset; cyc -1 = any cycle
  typedef struct {
    logic line;
    int   cyc;
  } edge_t;
  edge_t exp_q[$];

  logic prev_set = 1'b0, prev_rst = 1'b0, last_line = 1'b0, have_last = 1'b0;
  int   last_edge_cyc = 0;

  task automatic got_edge(input logic line);
    edge_t e;
    chk("edge_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("edge_line", line, e.line);
      if (e.cyc >= 0) chk("edge_cycle", cyc, e.cyc);
    end
    if (have_last && line != last_line) chk("edge_gap", (cyc - last_edge_cyc) >= GAP, 1);
    have_last     = 1'b1;
    last_line     = line;
    last_edge_cyc = cyc;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_set  = 1'b0;
      prev_rst  = 1'b0;
      have_last = 1'b0;
    end else begin
      if (set !== prev_set && reset !== prev_rst) chk("both_lines_toggled", 1'b1, 1'b0);
      else if (set !== prev_set) got_edge(1'b0);
      else if (reset !== prev_rst) got_edge(1'b1);
      prev_set = set;
      prev_rst = reset;
    end
  end

  task automatic push_exp(input logic line, input int at);
    edge_t e;
    e.line = line;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Offer one command; returns acceptance cycle and number of stalled cycles.
  task automatic send(input logic [1:0] op, output int acc, output int stalls);
    logic rdy;
    acc    = -1;
    stalls = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    while (acc < 0 && stalls < 50) begin
      rdy = cmd_if.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = cyc;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    cmd_if.cmd_valid = 1'b0;
    chk("accept_in_time", acc >= 0, 1);
  endtask

  task automatic wait_edges();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("edges_in_time", exp_q.size(), 0);
  endtask

  // Wait for all edges, then let the gap counter saturate.
  task automatic wait_idle();
    wait_edges();
    repeat (GAP + 2) @(negedge clk);
    chk("busy_idle", busy, 1'b0);
    chk("issued_cnt", issued_cnt, 32'(exp_cnt));
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
  endtask

  typedef struct {
    logic [1:0] op;
    int         set_at;  // offset from acceptance, -1 = no edge
    int         rd_at;
    int         dcnt;
  } vec_t;
  vec_t vecs[6];

  int a0, a1, st, stalls_total, first_acc, last_acc;

  initial begin
    vecs[0] = '{OP_NOP, -1, -1, 0};
    vecs[1] = '{OP_W1,   2, -1, 1};
    vecs[2] = '{OP_RD,  -1,  2, 1};
    vecs[3] = '{OP_W1R,  2,  5, 2};
    vecs[4] = '{OP_RD,  -1,  2, 1};
    vecs[5] = '{OP_W1,   2, -1, 1};

    rst              = 1'b1;
    dro_out          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    repeat (3) @(negedge clk);
    chk("rst_set", set, 1'b0);
    chk("rst_reset", reset, 1'b0);
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", issued_cnt, 0);
    chk("rst_mismatch", mismatch, 1'b0);
    rst = 1'b0;

`ifdef DRO_SHADOW_CHECK_EN
    // dro_out stuck low: the read after a write must flag a mismatch
    send(OP_W1, a0, st);
    push_exp(1'b0, a0 + 2);
    send(OP_RD, a1, st);
    push_exp(1'b1, -1);
    wait_edges();
    a1 = 0;
    while (mismatch !== 1'b1 && a1 < 6) begin
      @(negedge clk);
      a1++;
    end
    chk("shadow_mismatch_set", mismatch, 1'b1);
    repeat (5) @(negedge clk);
    chk("shadow_mismatch_held", mismatch, 1'b1);
    pulse_rst();
    #1;
    chk("shadow_mismatch_cleared", mismatch, 1'b0);
    repeat (GAP + 2) @(negedge clk);
`endif

    // Single-command vectors from a quiet, gap-satisfied state
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].op, a0, st);
      if (vecs[i].set_at >= 0) push_exp(1'b0, a0 + vecs[i].set_at);
      if (vecs[i].rd_at >= 0)  push_exp(1'b1, a0 + vecs[i].rd_at);
      exp_cnt += vecs[i].dcnt;
      wait_idle();
    end

    // READ then WRITE1: set is held off until GAP edges after the reset edge
    send(OP_RD, a0, st);
    push_exp(1'b1, a0 + 2);
    send(OP_W1, a1, st);
    chk("rd_w1_back_to_back", a1 - a0, 1);
    push_exp(1'b0, a0 + 5);
    exp_cnt += 2;
    wait_idle();

    // NOP then WRITE1: NOP takes a slot and a cycle, no edge
    send(OP_NOP, a0, st);
    send(OP_W1, a1, st);
    push_exp(1'b0, a0 + 3);
    exp_cnt += 1;
    wait_idle();

    // Six WRITE1_READ back to back: FIFO fills, ready drops until a pop
    stalls_total = 0;
    first_acc    = 0;
    last_acc     = 0;
    for (int i = 0; i < 6; i++) begin
      send(OP_W1R, a0, st);
      push_exp(1'b0, -1);
      push_exp(1'b1, -1);
      stalls_total += st;
      if (i == 0) first_acc = a0;
      if (i == 5) last_acc = a0;
    end
    chk("fifo_full_stalls", stalls_total, 2);
    chk("fifo_sixth_accept", last_acc - first_acc, 7);
    exp_cnt += 12;
    wait_idle();

    // Reset one cycle after the set edge of a WRITE1_READ
    send(OP_W1R, a0, st);
    push_exp(1'b0, a0 + 2);
    push_exp(1'b1, a0 + 5);
    while (cyc < a0 + 3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_set", set, 1'b0);
    chk("midrst_reset", reset, 1'b0);
    chk("midrst_cnt", issued_cnt, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", cmd_if.cmd_ready, 1'b1);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    send(OP_RD, a0, st);
    push_exp(1'b1, a0 + 2);
    exp_cnt += 1;
    wait_idle();

`ifndef DRO_SHADOW_CHECK_EN
    chk("mismatch_tied_low", mismatch, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end

endmodule
